fd_fetch_buffer: RTL
====================

Name: fd_fetch_buffer

Overview:
- Instruction buffer between the fetch unit (F) and the decode stage (D) of the 5-stage MIPS pipeline.
- Replaces the plain F/D pipeline register with a small circular FIFO holding {pc, instr} pairs.
- Absorbs single-cycle decode stalls without freezing the PC.
- Drives the fetch-stall signal back to the fetch unit and supports flush, optionally keeping the delay-slot instruction.

Parameters:
- DEPTH, 2, number of buffer entries; power of two, 2..8.
- XLEN, 32, width of PC and instruction.
- RESET_PC, 32'h00003000, PC value presented on d_pc while the buffer is empty or in reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- f_valid  input  1  fetch presents a valid instruction this cycle.
- f_pc  input  XLEN  PC of the fetched instruction.
- f_instr  input  XLEN  fetched instruction word.
- f_stall  output  1  to the fetch unit's PC-stall input; 1 = buffer full, hold PC.
- d_ready  input  1  decode accepts the head entry this cycle (equals not Stall_D).
- d_valid  output  1  head entry valid.
- d_pc  output  XLEN  PC of the head entry.
- d_instr  output  XLEN  instruction of the head entry; 32'h00000000 (nop) when empty.
- d_pc8  output  XLEN  d_pc + 8, the link address for jal/jalr.
- flush  input  1  discard all buffered entries.
- flush_keep_in  input  1  with flush, still enqueue the current f_* (branch delay slot).
- count  output  $clog2(DEPTH)+1  current occupancy, for debug and verification.

Behaviour:
- State: storage array DEPTH x {pc, instr}, head pointer hd, tail pointer tl (log2 DEPTH bits, wrap modulo DEPTH), and count.
- Reset (highest priority): hd=tl=0, count=0. Outputs: d_valid=0, d_instr=0, d_pc=RESET_PC, d_pc8=RESET_PC+8, f_stall=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries in that same edge, regardless of flush, f_valid or d_ready.
- Outputs are combinational from registered state only:
  - d_valid = (count!=0).
  - d_pc and d_instr come from entry[hd] when valid; otherwise RESET_PC and 0.
  - d_pc8 = d_pc + 8, modulo 2^XLEN.
- f_stall = (count==DEPTH), registered-state only.
  - No combinational path from d_ready to f_stall.
  - A full buffer refuses enqueue even when a dequeue happens in the same cycle.
- Handshakes:
  - enq = f_valid & ~f_stall.
  - deq = d_valid & d_ready.
- Latency: an instruction enqueued at edge n is visible on d_* after edge n. It can be dequeued at edge n+1 at the earliest. No bypass from F to D.
- Normal update, when neither reset nor flush is asserted:
  - enq writes entry[tl] and sets tl = tl+1.
  - deq sets hd = hd+1.
  - count = count + enq - deq. Simultaneous enq and deq leave count unchanged.
- Empty with d_ready=1: no dequeue and no state change.
- Full with f_valid=1: f_instr is ignored. The fetch unit holds the PC, so the same instruction is re-presented.
- Flush (priority over enq/deq, below reset):
  - Sets hd=0.
  - If flush_keep_in & f_valid: entry[0]={f_pc, f_instr}, tl=1, count=1.
  - Otherwise: tl=0, count=0.
  - f_stall is ignored for the kept instruction, because the buffer is emptied first.
  - flush_keep_in without flush has no effect.
- Pointer wrap: hd and tl wrap from DEPTH-1 to 0. count distinguishes full from empty when hd==tl.
- FIFO order is strict. No entry is ever dropped except by flush or reset.

Decomposition:
- Shared pipeline package holds:
  - constants NOP_INSTR=32'h00000000 and RESET_PC=32'h00003000;
  - typedef fd_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module: fd_buf_mem, the DEPTH-entry register array with a single write port (we, waddr, wdata) and an asynchronous read port (raddr), cleared by nothing.
- Pointers, count, flush logic and outputs stay in fd_fetch_buffer.

Test Plan:
- Reset then idle: expect d_valid=0, d_pc=32'h3000, d_pc8=32'h3008, d_instr=0, f_stall=0, count=0 for 3 cycles.
- Streaming: f_valid=1 with PC 0x3000/0x3004/0x3008 and instrs 0x24010001/0x24020002/0x24030003, d_ready=1. Expect D to show the same sequence one cycle later each; count stays 1; f_stall never asserted.
- Backpressure: d_ready=0 for 3 cycles while fetching 0x3000 and 0x3004. Expect count=2 and f_stall=1 after the second enqueue; 0x3008 is not enqueued. Then d_ready=1: expect 0x3000, 0x3004, 0x3008 in order with no loss or duplication.
- Wrap-around: 10 cycles alternating d_ready=1/0 with DEPTH=2. Expect hd/tl wrap, FIFO order preserved, and d_pc8 = d_pc+8 on every valid cycle.
- Flush with delay slot: buffer holds 0x3010 and 0x3014; flush=1, flush_keep_in=1, f_valid=1, f_pc=0x3018. Next cycle expect count=1, d_pc=0x3018. Repeating with flush_keep_in=0 gives count=0 and d_valid=0.
- Reset over flush: reset=1 and flush=1 and f_valid=1 in the same cycle. Expect count=0, d_valid=0, d_pc=32'h3000.

Source files
------------

// File: rtl/fd_fetch_buffer_pkg.sv
// Shared F/D pipeline definitions: reset PC, nop encoding and the buffered entry layout.
package fd_fetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000000;
  localparam logic [31:0] RESET_PC  = 32'h00003000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_entry_t;

endpackage

// File: rtl/fd_fetch_buffer_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
// Contents are never cleared; validity is tracked by the owning buffer.
module fd_buf_mem
  import fd_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read of the addressed entry.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/fd_fetch_buffer.sv
// F/D instruction buffer: small circular FIFO of {pc, instr} between fetch and decode.
// Absorbs decode stalls, back-pressures fetch when full, and supports flush with an
// optional kept delay-slot instruction. Outputs depend on registered state only.
module fd_fetch_buffer
  import fd_fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(fd_fetch_buffer_pkg::RESET_PC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_valid,
  input  logic [XLEN-1:0]          f_pc,
  input  logic [XLEN-1:0]          f_instr,
  output logic                     f_stall,
  input  logic                     d_ready,
  output logic                     d_valid,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_instr,
  output logic [XLEN-1:0]          d_pc8,
  input  logic                     flush,
  input  logic                     flush_keep_in,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 2 * XLEN;

  logic [AW-1:0] hd;
  logic [AW-1:0] tl;
  logic [CW-1:0] cnt;

  logic          enq;
  logic          deq;
  logic          keep;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_rdata;

  // Handshakes and status, all derived from registered occupancy (no d_ready -> f_stall path).
  always_comb begin
    f_stall = (cnt == CW'(DEPTH));
    d_valid = (cnt != '0);
    enq     = f_valid & ~f_stall;
    deq     = d_valid & d_ready;
    keep    = flush_keep_in & f_valid;
    count   = cnt;
  end

  // Storage write: a flush empties the buffer first, so a kept instruction lands in entry 0.
  always_comb begin
    mem_we    = enq;
    mem_waddr = tl;
    if (flush) begin
      mem_we    = keep;
      mem_waddr = '0;
    end
  end

  fd_buf_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata ({f_pc, f_instr}),
    .raddr (hd),
    .rdata (mem_rdata)
  );

  // Pointer and occupancy update: reset, then flush, then normal enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (reset) begin
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else if (flush) begin
      hd  <= '0;
      tl  <= keep ? AW'(1) : '0;
      cnt <= keep ? CW'(1) : '0;
    end else begin
      hd  <= hd + AW'(deq);
      tl  <= tl + AW'(enq);
      cnt <= cnt + CW'(enq) - CW'(deq);
    end
  end

  // Head entry presentation; idle values when empty.
  always_comb begin
    if (d_valid) begin
      d_pc    = mem_rdata[W-1:XLEN];
      d_instr = mem_rdata[XLEN-1:0];
    end else begin
      d_pc    = RESET_PC;
      d_instr = XLEN'(NOP_INSTR);
    end
    d_pc8 = d_pc + XLEN'(8);
  end

endmodule
